dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Initiator-side controller that sits in the CPU MEM stage and drives the 12 KB byte-addressable data memory (`dm` port set: addr/din/we/byteOp/dout).

- Accepts one load or store at a time from the pipeline over a req/ready/done handshake.
- Range- and alignment-checks the address, then sequences the memory's synchronous write or combinational read.
- Registers the load result and returns it with a one-cycle `done` pulse.
- Keeps saturating load/store/fault counters for debug.

## Interface
Parameters:
- `DM_BYTES`, 12288: memory size in bytes; valid byte addresses are 0..DM_BYTES-1.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request from the pipeline; sampled only when `ready`=1.
- `wr`  in  1  1 = store, 0 = load; sampled with `req`.
- `byte_op`  in  1  1 = byte access (lb/sb), 0 = word access (lw/sw).
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; only bits [7:0] are used for byte stores.
- `ready`  out  1  controller idle and able to accept `req`.
- `done`  out  1  one-cycle pulse: access complete.
- `rdata`  out  32  load result; valid while `done`=1 and held until the next `done`.
- `fault`  out  1  qualifies `done`: access rejected.
- `dm_addr`  out  14  memory byte address.
- `dm_din`  out  32  memory write data.
- `dm_we`  out  1  memory write enable.
- `dm_byteOp`  out  1  memory byte-mode select.
- `dm_dout`  in  32  memory read data (combinational from `dm_addr`; byte mode is already sign-extended by the memory).
- `load_cnt`, `store_cnt`, `fault_cnt`  out  CNT_W  saturating counters.

## Operation
FSM states and transitions:
- IDLE: `ready`=1.
  - `req`=1 → latch `wr`, `byte_op`, `addr`[13:0] and `wdata` into request registers, then run the checks.
  - Go to FAULT if either holds:
    - `addr` ≥ DM_BYTES, or word access with `addr` > DM_BYTES-4.
    - Word access with `addr`[1:0] ≠ 0.
  - Otherwise go to WRITE if `wr`=1, else READ.
  - `req`=0 → stay in IDLE.
- READ:
  - `dm_addr`/`dm_byteOp` come from the request registers.
  - Capture `dm_dout` into `rdata` at the clock edge, then go to RESP.
- WRITE:
  - `dm_we`=1 for exactly this one cycle; `dm_din` = latched `wdata`; `dm_addr`/`dm_byteOp` from the request registers.
  - Then go to RESP.
- FAULT:
  - `dm_we` stays 0 and `rdata` is unchanged.
  - Set the registered fault flag, then go to RESP.
- RESP:
  - `done`=1, `fault` = fault flag, `ready`=0.
  - Always go to IDLE next.
  - A `req` in this cycle is ignored; the requester must hold it until `ready`.

Other rules:
- `dm_we` is asserted only in WRITE. `dm_din`, `dm_addr` and `dm_byteOp` are driven from registers in all states, so there is no combinational path from `addr`/`wdata` to the memory.
- Counters update at the RESP→IDLE transition:
  - `load_cnt`+1 on a good load, `store_cnt`+1 on a good store, `fault_cnt`+1 on a fault.
  - Each counter saturates at all-ones.
- Byte store writes only `wdata`[7:0] to `addr`. Word store writes little-endian: byte 0 is at `addr`.

## Timing
- Reset (async, while `rst_n`=0):
  - State IDLE, `ready`=1.
  - `done`=0, `fault`=0, `rdata`=0.
  - `dm_we`=0, `dm_addr`=0, `dm_din`=0, `dm_byteOp`=0.
  - All counters 0.
- Latency: `req` accepted at edge N → `done` high during cycle N+2 (good or fault).
- Throughput: one access every 3 cycles; `ready` returns high in cycle N+3.
- Store data is in memory after edge N+2, so a load accepted at N+3 sees it.
- Reset asserted mid-access: `dm_we` drops immediately, no `done` is produced, and the pending access is discarded. A WRITE interrupted before its edge does not commit.
- `req` with `ready`=0 has no effect.

## Test plan
- Reset then idle: `rst_n` low for 2 cycles, then `req`=0 for 5 cycles → `ready`=1, `done`=0, all outputs 0, counters 0.
- Word round trip: sw `addr`=0x100, `wdata`=0xDEADBEEF → `done` 2 cycles after accept with `fault`=0. Then lw 0x100 → `rdata`=0xDEADBEEF, and lb 0x103 → `rdata`=0xFFFFFFDE. `store_cnt`=1, `load_cnt`=2.
- Byte store: sb `addr`=0x201, `wdata`=0x12345677 → lw 0x200 returns 0x00007700, with all other bytes unchanged from 0.
- Faults:
  - lw 0x102 (misaligned) → `done`=1, `fault`=1, `rdata` unchanged, `dm_we` never asserted.
  - sw 0x2FFE and sb 0x3000 → `fault`=1.
  - `fault_cnt`=3.
- Back-to-back: `req` held high for 9 cycles → exactly 3 accesses, `done` at cycles 2, 5, 8 after the first accept.
- Reset mid-access: assert `rst_n`=0 during WRITE of sw 0x40 = 0xFFFFFFFF → no `done`; a subsequent lw 0x40 returns 0 and `store_cnt`=0.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Pipeline-side request/response bundle for the data-memory access controller.
// The pipeline (master) issues one access at a time; the controller (slave) answers with done/fault/rdata.
interface dm_access_ctrl_if;
    logic        req;
    logic        wr;
    logic        byte_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        fault;

    modport master (
        output req, wr, byte_op, addr, wdata,
        input  ready, done, rdata, fault
    );

    modport slave (
        input  req, wr, byte_op, addr, wdata,
        output ready, done, rdata, fault
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage controller for the byte-addressable data memory: one access in flight,
// range/alignment checking, registered load data, and saturating debug counters.
module dm_access_ctrl #(
    parameter int DM_BYTES = 12288,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus,
    output logic [13:0]       dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    output logic              dm_byteOp,
    input  logic [31:0]       dm_dout,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt,
    output logic [CNT_W-1:0]  fault_cnt
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] FAULT = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [31:0] LAST_BYTE = 32'(DM_BYTES - 1);
    localparam logic [31:0] LAST_WORD = 32'(DM_BYTES - 4);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        r_wr;
    logic        fault_flag;
    logic [31:0] rdata_q;
    logic        bad_access;

    // A word must fit entirely inside the memory and sit on a 4-byte boundary.
    always_comb begin
        bad_access = (bus.addr > LAST_BYTE)
                  || (!bus.byte_op && (bus.addr > LAST_WORD))
                  || (!bus.byte_op && (bus.addr[1:0] != 2'b00));
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad_access)  state_nxt = FAULT;
                    else if (bus.wr) state_nxt = WRITE;
                    else             state_nxt = READ;
                end
            end
            READ, WRITE, FAULT: state_nxt = RESP;
            RESP:               state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_wr       <= 1'b0;
            dm_byteOp  <= 1'b0;
            dm_addr    <= '0;
            dm_din     <= '0;
            fault_flag <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        r_wr       <= bus.wr;
                        dm_byteOp  <= bus.byte_op;
                        dm_addr    <= bus.addr[13:0];
                        dm_din     <= bus.wdata;
                        fault_flag <= 1'b0;
                    end
                end
                READ:    rdata_q    <= dm_dout;
                FAULT:   fault_flag <= 1'b1;
                default: ;
            endcase
        end
    end

    // Counters advance on the RESP->IDLE edge and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            fault_cnt <= '0;
        end else if (state == RESP) begin
            if (fault_flag) begin
                if (fault_cnt != '1) fault_cnt <= fault_cnt + CNT_W'(1);
            end else if (r_wr) begin
                if (store_cnt != '1) store_cnt <= store_cnt + CNT_W'(1);
            end else begin
                if (load_cnt != '1)  load_cnt  <= load_cnt + CNT_W'(1);
            end
        end
    end

    // dm_we is decoded from the state register, so an async reset drops it at once.
    assign dm_we     = (state == WRITE);
    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == RESP);
    assign bus.fault = (state == RESP) && fault_flag;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: behavioural data memory, a shadow reference memory
// and a scoreboard of expected done/fault/rdata/latency per accepted access.
module tb_dm_access_ctrl;

    localparam int DM_BYTES = 12288;
    localparam int CNT_W    = 16;

    logic              clk;
    logic              rst_n;
    logic [13:0]       dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic              dm_byteOp;
    logic [31:0]       dm_dout;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;
    logic [CNT_W-1:0]  fault_cnt;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.DM_BYTES(DM_BYTES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_we     (dm_we),
        .dm_byteOp (dm_byteOp),
        .dm_dout   (dm_dout),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .fault_cnt (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT (sized to the full 14-bit space so any dm_addr is a legal index).
    logic [7:0] mem     [16384];
    logic [7:0] ref_mem [16384];

    always @(posedge clk) begin
        if (dm_we) begin
            if (dm_byteOp) begin
                mem[dm_addr] <= dm_din[7:0];
            end else begin
                mem[dm_addr]          <= dm_din[7:0];
                mem[dm_addr + 14'd1]  <= dm_din[15:8];
                mem[dm_addr + 14'd2]  <= dm_din[23:16];
                mem[dm_addr + 14'd3]  <= dm_din[31:24];
            end
        end
    end

    assign dm_dout = dm_byteOp ? {{24{mem[dm_addr][7]}}, mem[dm_addr]}
                               : {mem[dm_addr + 14'd3], mem[dm_addr + 14'd2],
                                  mem[dm_addr + 14'd1], mem[dm_addr]};

    typedef struct {
        string       name;
        logic        fault;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pcyc   = 0;
    logic [31:0] hold   = 32'h0;
    bit          we_seen = 1'b0;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Response monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_we) we_seen = 1'b1;
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done at cycle %0d", pcyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checks++;
                    if (bus.fault !== e.fault) begin
                        errors++;
                        $display("FAIL %s fault got %b want %b", e.name, bus.fault, e.fault);
                    end
                    checks++;
                    if (bus.rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL %s rdata got %h want %h", e.name, bus.rdata, e.rdata);
                    end
                    checks++;
                    if (pcyc != e.due) begin
                        errors++;
                        $display("FAIL %s latency done at cycle %0d want %0d", e.name, pcyc, e.due);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ref_read(input bit b, input int a);
        if (b) return {{24{ref_mem[a][7]}}, ref_mem[a]};
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // Called at a negedge with ready=1 just before the accepting posedge.
    function automatic void push_expect(input string name, input bit w, input bit b,
                                        input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   bad;
        int   ai;
        bad = (a >= 32'd12288) || (!b && ((a > 32'd12284) || (a[1:0] != 2'b00)));
        ai  = int'(a[13:0]);
        if (!bad && !w) hold = ref_read(b, ai);
        if (!bad && w) begin
            ref_mem[ai] = d[7:0];
            if (!b) begin
                ref_mem[ai+1] = d[15:8];
                ref_mem[ai+2] = d[23:16];
                ref_mem[ai+3] = d[31:24];
            end
        end
        e.name  = name;
        e.fault = bad;
        e.rdata = hold;
        e.due   = pcyc + 2;
        sb_q.push_back(e);
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout got %b want 1", name, bus.ready);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s done_timeout pending %0d want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_access(input string name, input bit w, input bit b,
                             input logic [31:0] a, input logic [31:0] d);
        wait_ready(name);
        bus.req = 1'b1; bus.wr = w; bus.byte_op = b; bus.addr = a; bus.wdata = d;
        push_expect(name, w, b, a, d);
        @(posedge clk);
        #1 bus.req = 1'b0;
        drain(name);
        wait_ready(name);
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] got, input int want);
        checks++;
        if (got !== CNT_W'(want)) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.fault); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we got %b want 0", dm_we); end
        checks++; if (dm_addr !== 14'h0) begin errors++; $display("FAIL reset_dm_addr got %h want 0", dm_addr); end
        checks++; if (dm_din !== 32'h0) begin errors++; $display("FAIL reset_dm_din got %h want 0", dm_din); end
        checks++; if (dm_byteOp !== 1'b0) begin errors++; $display("FAIL reset_dm_byteOp got %b want 0", dm_byteOp); end
        check_cnt("reset_load_cnt", load_cnt, 0);
        check_cnt("reset_store_cnt", store_cnt, 0);
        check_cnt("reset_fault_cnt", fault_cnt, 0);
    endtask

    task automatic test_word_round_trip;
        do_access("sw_100", 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
        do_access("lw_100", 1'b0, 1'b0, 32'h100, 32'h0);
        do_access("lb_103", 1'b0, 1'b1, 32'h103, 32'h0);
        check_cnt("rt_store_cnt", store_cnt, 1);
        check_cnt("rt_load_cnt", load_cnt, 2);
    endtask

    task automatic test_byte_store;
        do_access("sb_201", 1'b1, 1'b1, 32'h201, 32'h12345677);
        do_access("lw_200", 1'b0, 1'b0, 32'h200, 32'h0);
        checks++;
        if (hold !== 32'h00007700) begin
            errors++;
            $display("FAIL sb_model got %h want 00007700", hold);
        end
    endtask

    task automatic test_faults;
        we_seen = 1'b0;
        do_access("lw_102_misaligned", 1'b0, 1'b0, 32'h102, 32'h0);
        do_access("sw_2ffe_range", 1'b1, 1'b0, 32'h2FFE, 32'hCAFEF00D);
        do_access("sb_3000_range", 1'b1, 1'b1, 32'h3000, 32'h000000AA);
        checks++;
        if (we_seen) begin errors++; $display("FAIL fault_dm_we got 1 want 0"); end
        check_cnt("fault_cnt", fault_cnt, 3);
        do_access("lw_2ffc_last_word", 1'b0, 1'b0, 32'h2FFC, 32'h0);
        do_access("lb_2fff_last_byte", 1'b0, 1'b1, 32'h2FFF, 32'h0);
        do_access("lw_high_addr", 1'b0, 1'b0, 32'h8000_0100, 32'h0);
        check_cnt("fault_cnt_after", fault_cnt, 4);
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        wait_ready("b2b");
        bus.req = 1'b1; bus.wr = 1'b0; bus.byte_op = 1'b0; bus.addr = 32'h100; bus.wdata = 32'h0;
        for (int i = 0; i < 9; i++) begin
            if (bus.ready === 1'b1) begin
                push_expect($sformatf("b2b_%0d", accepts), 1'b0, 1'b0, 32'h100, 32'h0);
                accepts++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.req = 1'b0;
        drain("b2b");
        wait_ready("b2b");
        checks++;
        if (accepts != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", accepts); end
    endtask

    task automatic test_reset_mid_access;
        wait_ready("rst_mid");
        bus.req = 1'b1; bus.wr = 1'b1; bus.byte_op = 1'b0; bus.addr = 32'h40; bus.wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1 bus.req = 1'b0;
        checks++;
        if (dm_we !== 1'b1) begin errors++; $display("FAIL rst_mid_we_before got %b want 1", dm_we); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we_after got %b want 0", dm_we); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
        hold = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_access("lw_40_after_rst", 1'b0, 1'b0, 32'h40, 32'h0);
        check_cnt("rst_mid_store_cnt", store_cnt, 0);
        check_cnt("rst_mid_load_cnt", load_cnt, 1);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.req = 1'b0; bus.wr = 1'b0; bus.byte_op = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        test_reset();
        test_word_round_trip();
        test_byte_store();
        test_faults();
        test_back_to_back();
        test_reset_mid_access();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
